// File: rtl/tmds_encode_if.sv
// -----------------------------------------------------------------------------
// tmds_encode_if
// Pixel-side bundle for one TMDS encoder channel.
//   i_vde   : 1 = video data period, 0 = control period
//   i_ctrl  : {c1, c0} control bits (blue channel: {vsync, hsync})
//   i_data  : 8-bit pixel component
//   o_tmds  : 10-bit encoded word, bit 0 serialized first
// master drives the pixel stream and receives the word; slave is the encoder.
// -----------------------------------------------------------------------------
interface tmds_encode_if;
   logic       i_vde;
   logic [1:0] i_ctrl;
   logic [7:0] i_data;
   logic [9:0] o_tmds;

   modport master (output i_vde, output i_ctrl, output i_data, input o_tmds);
   modport slave  (input i_vde, input i_ctrl, input i_data, output o_tmds);
endinterface

// File: rtl/tmds_encode.sv
// -----------------------------------------------------------------------------
// tmds_encode
// DVI/HDMI TMDS 8b/10b encoder for one channel with running-disparity
// DC balance. Fixed three-register pipeline: inputs sampled at edge k show
// up on o_tmds after edge k+2. One word per clock, no handshake.
// Ports:
//   clk   : pixel clock, rising edge
//   rstn  : asynchronous active-low reset (output forced to control token 00)
//   bus   : tmds_encode_if.slave (i_vde, i_ctrl, i_data in; o_tmds out)
// -----------------------------------------------------------------------------
module tmds_encode (
   input logic          clk,
   input logic          rstn,
   tmds_encode_if.slave bus
);

   localparam logic [9:0] TOK_00 = 10'b1101010100;
   localparam logic [9:0] TOK_01 = 10'b0010101011;
   localparam logic [9:0] TOK_10 = 10'b0101010100;
   localparam logic [9:0] TOK_11 = 10'b1010101011;

   function automatic logic [3:0] ones8(input logic [7:0] v);
      logic [3:0] n;
      n = 4'd0;
      for (int i = 0; i < 8; i++) n = n + {3'd0, v[i]};
      return n;
   endfunction

   // Transition-minimised 9-bit word; bit 8 = 1 marks the XOR chain.
   function automatic logic [8:0] trans_min(input logic [7:0] d);
      logic [3:0] n1d;
      logic       use_xnor;
      logic [8:0] q;
      n1d      = ones8(d);
      use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !d[0]);
      q        = '0;
      q[0]     = d[0];
      for (int i = 1; i < 8; i++)
         q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
      q[8] = ~use_xnor;
      return q;
   endfunction

   logic [8:0]        qm_p0;
   logic              vde_p0;
   logic [1:0]        ctrl_p0;

   logic [8:0]        qm_p1;
   logic [3:0]        n1q_p1;
   logic [3:0]        n0q_p1;
   logic              vde_p1;
   logic [1:0]        ctrl_p1;

   logic [9:0]        tmds_q;
   logic signed [4:0] cnt;

   logic [9:0]        tmds_d;
   logic signed [4:0] cnt_d;
   logic signed [4:0] diff;
   logic [7:0]        qm_lo;
   logic              qm8;

   assign qm_lo = qm_p1[7:0];
   assign qm8   = qm_p1[8];
   // n1q - n0q, both 0..8, so it fits a 5-bit signed value.
   assign diff  = $signed({1'b0, n1q_p1}) - $signed({1'b0, n0q_p1});

   // ---- stage 3: DC balance / control token selection ----
   always_comb begin
      tmds_d = TOK_00;
      cnt_d  = '0;
      if (!vde_p1) begin
         case (ctrl_p1)
            2'b00:   tmds_d = TOK_00;
            2'b01:   tmds_d = TOK_01;
            2'b10:   tmds_d = TOK_10;
            default: tmds_d = TOK_11;
         endcase
         cnt_d = '0;
      end else if ((cnt == 5'sd0) || (n1q_p1 == n0q_p1)) begin
         tmds_d = {~qm8, qm8, (qm8 ? qm_lo : ~qm_lo)};
         cnt_d  = qm8 ? (cnt + diff) : (cnt - diff);
      end else if ((!cnt[4] && (n1q_p1 > n0q_p1)) || (cnt[4] && (n0q_p1 > n1q_p1))) begin
         // cnt is nonzero here, so the sign bit alone distinguishes >0 from <0.
         tmds_d = {1'b1, qm8, ~qm_lo};
         cnt_d  = cnt + (qm8 ? 5'sd2 : 5'sd0) - diff;
      end else begin
         tmds_d = {1'b0, qm8, qm_lo};
         cnt_d  = cnt + diff - (qm8 ? 5'sd0 : 5'sd2);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         qm_p0   <= '0;
         vde_p0  <= 1'b0;
         ctrl_p0 <= 2'b00;
         qm_p1   <= '0;
         n1q_p1  <= '0;
         n0q_p1  <= '0;
         vde_p1  <= 1'b0;
         ctrl_p1 <= 2'b00;
         tmds_q  <= TOK_00;
         cnt     <= '0;
      end else begin
         // ---- stage 1: transition minimisation ----
         qm_p0   <= trans_min(bus.i_data);
         vde_p0  <= bus.i_vde;
         ctrl_p0 <= bus.i_ctrl;
         // ---- stage 2: ones/zeros count of qm[7:0] ----
         qm_p1   <= qm_p0;
         n1q_p1  <= ones8(qm_p0[7:0]);
         n0q_p1  <= 4'd8 - ones8(qm_p0[7:0]);
         vde_p1  <= vde_p0;
         ctrl_p1 <= ctrl_p0;
         // ---- stage 3 register: output word and running disparity ----
         tmds_q  <= tmds_d;
         cnt     <= cnt_d;
      end
   end

   assign bus.o_tmds = tmds_q;

endmodule
